// File: rtl/gsim_matvec_if.sv
// Stream interface for gsim_matvec: x-vector load port and b-vector output port.
interface gsim_matvec_if #(
    parameter int XW = 32
);
    logic          in_en;
    logic [XW-1:0] x_in;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [XW-1:0] b_out;
    logic          out_last;

    modport master (
        output in_en, x_in, out_ready,
        input  in_ready, out_valid, b_out, out_last
    );

    modport slave (
        input  in_en, x_in, out_ready,
        output in_ready, out_valid, b_out, out_last
    );
endinterface

// File: rtl/gsim_matvec.sv
// b = A*x for the fixed 16x16 banded GSIM matrix, streamed out with backpressure.
// Optional GSIM_MATVEC_SAT_EN clamps the Q16.16 result instead of wrapping; N must be a power of two.
module gsim_matvec #(
    parameter int N    = 16,
    parameter int XW   = 32,
    parameter int ACCW = 39
) (
    input  logic          clk,
    input  logic          reset,
    gsim_matvec_if.slave  bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_load_cnt;
    logic [IW-1:0]   r_out_cnt;
    logic [XW-1:0]   r_x [N];
    logic [XW-1:0]   r_b_out;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_in_ready;

    logic [IW-1:0]         w_row_idx;
    logic [IW+1:0]         w_pos;
    logic signed [ACCW-1:0] w_nb [7];
    logic signed [ACCW-1:0] w_s1, w_s2, w_s3, w_acc;
    logic [XW-1:0]         w_b;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.b_out     = r_b_out;
    assign bus.out_last  = r_out_last;

    // Row being computed: row 0 in CALC, next row while presenting the current one in OUT.
    assign w_row_idx = (r_state == S_OUT) ? r_out_cnt + IW'(1) : '0;

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        w_pos = '0;
        for (int j = 0; j < 7; j++) begin
            w_pos    = {2'b00, w_row_idx} + (IW+2)'(j) - (IW+2)'(3);
            w_nb[j]  = '0;
            // Top two bits are 00 only for 0..N-1; negative or past-the-end neighbours stay zero.
            if (w_pos[IW+1:IW] == 2'b00) begin
                w_nb[j] = ACCW'($signed(r_x[w_pos[IW-1:0]]));
            end
        end
    end

    assign w_s1  = w_nb[2] + w_nb[4];
    assign w_s2  = w_nb[1] + w_nb[5];
    assign w_s3  = w_nb[0] + w_nb[6];
    assign w_acc = (w_nb[3] <<< 4) + (w_nb[3] <<< 2)
                 - ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
                 + ((w_s2 <<< 2) + (w_s2 <<< 1))
                 - w_s3;

`ifdef GSIM_MATVEC_SAT_EN
    always_comb begin
        w_b = w_acc[XW-1:0];
        if (!w_acc[ACCW-1] && |w_acc[ACCW-2:XW-1]) begin
            w_b = {1'b0, {(XW-1){1'b1}}};
        end else if (w_acc[ACCW-1] && !(&w_acc[ACCW-2:XW-1])) begin
            w_b = {1'b1, {(XW-1){1'b0}}};
        end
    end
`else
    assign w_b = w_acc[XW-1:0];
    logic w_unused_acc_hi;
    assign w_unused_acc_hi = ^w_acc[ACCW-1:XW];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_out_cnt   <= '0;
            r_b_out     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            // NOTE: the x store is reset too, since a cleared vector is part of the defined reset state.
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_en) begin
                        r_x[r_load_cnt] <= bus.x_in;
                        if (r_load_cnt == IW'(N-1)) begin
                            r_load_cnt <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_CALC;
                        end else begin
                            r_load_cnt <= r_load_cnt + IW'(1);
                        end
                    end
                end
                S_CALC: begin
                    r_b_out     <= w_b;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    r_out_cnt   <= '0;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (r_out_cnt == IW'(N-1)) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_cnt   <= '0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_b_out    <= w_b;
                            r_out_cnt  <= w_row_idx;
                            r_out_last <= (w_row_idx == IW'(N-1));
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gsim_matvec.sv
// Scoreboard bench for gsim_matvec: stimulus pushes expected b elements, a monitor pops on each transfer.
module tb_gsim_matvec;
    localparam int N = 16;

    typedef logic [31:0] vec_t [N];
    typedef struct packed {
        logic [31:0] b;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gsim_matvec_if u_if ();

    gsim_matvec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    bit   bp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Straightforward reference: integer coefficients times neighbours, wide arithmetic.
    function automatic logic [31:0] ref_b(input vec_t x, input int i);
        longint acc;
        int     c [4];
        c[0] = 20; c[1] = -13; c[2] = 6; c[3] = -1;
        acc = 0;
        for (int k = -3; k <= 3; k++) begin
            if (i + k >= 0 && i + k < N) begin
                acc += longint'(c[(k < 0) ? -k : k]) * longint'($signed(x[i+k]));
            end
        end
`ifdef GSIM_MATVEC_SAT_EN
        if (acc > 64'sh7FFFFFFF)       return 32'h7FFFFFFF;
        if (acc < -64'sh80000000)      return 32'h80000000;
`endif
        return acc[31:0];
    endfunction

    task automatic push_exp(input vec_t b);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.b    = b[i];
            e.last = (i == N-1);
            sb_q.push_back(e);
        end
    endtask

    task automatic load_vec(input vec_t v, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                u_if.in_en = 1'b0;
                u_if.x_in  = 32'hDEAD_BEEF;
                @(posedge clk); #1;
            end
            u_if.in_en = 1'b1;
            u_if.x_in  = v[i];
            @(posedge clk); #1;
        end
        u_if.in_en = 1'b0;
        u_if.x_in  = '0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (sb_q.size() > 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: %0d elements still expected after %0d cycles", name, sb_q.size(), cyc);
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Output monitor: pops on each transfer, and checks that a stalled element holds steady.
    initial begin
        logic        hold;
        logic [31:0] hold_b;
        logic        hold_l;
        exp_t        e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", {31'd0, u_if.out_valid}, 32'd1);
                    check("hold_b", u_if.b_out, hold_b);
                    check("hold_last", {31'd0, u_if.out_last}, {31'd0, hold_l});
                end
                hold = 1'b0;
                if (u_if.out_valid === 1'b1) begin
                    if (u_if.out_ready === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_out: got b=%h with nothing expected", u_if.b_out);
                        end else begin
                            e = sb_q.pop_front();
                            check($sformatf("b_out[%0d]", n_xfer % N), u_if.b_out, e.b);
                            check($sformatf("out_last[%0d]", n_xfer % N), {31'd0, u_if.out_last}, {31'd0, e.last});
                        end
                        n_xfer++;
                    end else begin
                        hold   = 1'b1;
                        hold_b = u_if.b_out;
                        hold_l = u_if.out_last;
                    end
                end
            end
        end
    end

    // Downstream ready: always on, or a 50% coin flip while backpressure is enabled.
    initial begin
        u_if.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            u_if.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v_zero, v_one, v_t2, v_alt, b_zero, b_t2, b_t3, b_alt;
        int   base, cyc;

        for (int i = 0; i < N; i++) begin
            v_zero[i] = 32'h0;
            v_one[i]  = 32'h0001_0000;
            v_t2[i]   = 32'h0;
            v_alt[i]  = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0001;
            b_zero[i] = 32'h0;
            b_t2[i]   = 32'h0;
            b_t3[i]   = 32'h0004_0000;
        end
        v_t2[0] = 32'h0001_0000;
        b_t2[0] = 32'h0014_0000; b_t2[1] = 32'hFFF3_0000;
        b_t2[2] = 32'h0006_0000; b_t2[3] = 32'hFFFF_0000;
        b_t3[0]  = 32'h000C_0000; b_t3[1]  = 32'hFFFF_0000; b_t3[2]  = 32'h0005_0000;
        b_t3[13] = 32'h0005_0000; b_t3[14] = 32'hFFFF_0000; b_t3[15] = 32'h000C_0000;
        for (int i = 0; i < N; i++) begin
            b_alt[i] = ref_b(v_alt, i);
        end

        reset      = 1'b0;
        u_if.in_en = 1'b0;
        u_if.x_in  = '0;
        #12;
        check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("rst_out_last", {31'd0, u_if.out_last}, 32'd0);
        check("rst_b_out", u_if.b_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Test 1: all zeros
        push_exp(b_zero);
        load_vec(v_zero, 1'b0);
        drain("t1");
        check("t1_in_ready_after", {31'd0, u_if.in_ready}, 32'd1);
        check("t1_out_valid_after", {31'd0, u_if.out_valid}, 32'd0);

        // Test 2: unit impulse at x[0]
        push_exp(b_t2);
        load_vec(v_t2, 1'b0);
        drain("t2");

        // Test 3: all ones, first-output latency, in_en ignored outside LOAD
        push_exp(b_t3);
        load_vec(v_one, 1'b0);
        check("t3_calc_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("t3_calc_in_ready", {31'd0, u_if.in_ready}, 32'd0);
        u_if.in_en = 1'b1;
        u_if.x_in  = 32'h1234_5678;
        @(posedge clk); #1;
        check("t3_first_valid", {31'd0, u_if.out_valid}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        u_if.in_en = 1'b0;
        u_if.x_in  = '0;
        drain("t3");

        // Test 4: alternating extremes, saturating or wrapping by build
        push_exp(b_alt);
        load_vec(v_alt, 1'b0);
        drain("t4");

        // Test 5: random backpressure and input gaps
        bp_en = 1'b1;
        push_exp(b_t3);
        load_vec(v_one, 1'b1);
        drain("t5");
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Test 6: asynchronous reset while the 8th element is on the bus
        push_exp(b_t3);
        base = n_xfer;
        load_vec(v_one, 1'b0);
        cyc = 0;
        while (n_xfer < base + 7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (n_xfer < base + 7) begin
            n_tests++;
            n_fail++;
            $display("FAIL t6_wait: got %0d transfers expected %0d", n_xfer - base, 7);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("t6_async_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        push_exp(b_t2);
        load_vec(v_t2, 1'b0);
        drain("t6");

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
